mips32_pipeline: RTL and testbench

- Self-contained 5-stage (IF, ID, EX, MEM, WB) 32-bit MIPS-subset processor core with internal register file and unified word-addressed instruction/data memory.
- Runs from PC 0 after reset until an HLT instruction retires, then freezes.
- Benches preload `Reg` and `mem` and inspect state hierarchically; used as a standalone CPU block.

---
 rtl/mips32_pkg.sv | 80 ++++++++
 rtl/mips32_alu.sv | 26 ++
 rtl/mips32_pipeline.sv | 150 +++++++++++++++
 tb/tb_mips32_pipeline.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/mips32_pkg.sv
// Shared opcodes, instruction classes and pipeline-register layouts for the mips32 core.
// MIPS32_MUL_EN makes the MUL opcode decode as a register-register ALU operation.
package mips32_pkg;

  localparam int unsigned XLEN = 32;

  typedef logic [XLEN-1:0] word_t;
  typedef logic [5:0]      opcode_t;

  localparam opcode_t OpAdd   = 6'b000000;
  localparam opcode_t OpSub   = 6'b000001;
  localparam opcode_t OpAnd   = 6'b000010;
  localparam opcode_t OpOr    = 6'b000011;
  localparam opcode_t OpSlt   = 6'b000100;
  localparam opcode_t OpMul   = 6'b000101;
  localparam opcode_t OpLw    = 6'b001000;
  localparam opcode_t OpSw    = 6'b001001;
  localparam opcode_t OpAddi  = 6'b001010;
  localparam opcode_t OpSubi  = 6'b001011;
  localparam opcode_t OpSlti  = 6'b001100;
  localparam opcode_t OpBneqz = 6'b001101;
  localparam opcode_t OpBeqz  = 6'b001110;
  localparam opcode_t OpHlt   = 6'b111111;

  typedef enum logic [2:0] {RR_ALU, RM_ALU, LOAD, STORE, BRANCH, HALT, NOP} instr_class_e;

  typedef struct packed {
    logic  valid;
    word_t pc;
    word_t ir;
  } if_id_t;

  typedef struct packed {
    logic         valid;
    word_t        pc;
    opcode_t      op;
    logic [4:0]   rs;
    logic [4:0]   rt;
    logic [4:0]   rd;
    instr_class_e cls;
    word_t        a;
    word_t        b;
    word_t        imm;
  } id_ex_t;

  typedef struct packed {
    logic         valid;
    instr_class_e cls;
    word_t        alu_out;
    word_t        b;
    logic [4:0]   dest;
    logic         wr_en;
  } ex_mem_t;

  typedef struct packed {
    logic         valid;
    instr_class_e cls;
    word_t        result;
    logic [4:0]   dest;
    logic         wr_en;
  } mem_wb_t;

  function automatic instr_class_e decode_class(input opcode_t op);
    instr_class_e cls;
    case (op)
      OpAdd, OpSub, OpAnd, OpOr, OpSlt: cls = RR_ALU;
`ifdef MIPS32_MUL_EN
      OpMul:                            cls = RR_ALU;
`endif
      OpAddi, OpSubi, OpSlti:           cls = RM_ALU;
      OpLw:                             cls = LOAD;
      OpSw:                             cls = STORE;
      OpBneqz, OpBeqz:                  cls = BRANCH;
      OpHlt:                            cls = HALT;
      default:                          cls = NOP;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/mips32_alu.sv
// Combinational ALU for the mips32 core; address generation for LW/SW uses the add path.
// The multiplier exists only when MIPS32_MUL_EN is defined.
module mips32_alu
  import mips32_pkg::*;
(
  input  opcode_t i_opcode,
  input  word_t   i_a,
  input  word_t   i_b,
  output word_t   o_result
);

  always_comb begin
    o_result = i_a + i_b;
    case (i_opcode)
      OpSub, OpSubi: o_result = i_a - i_b;
      OpAnd:         o_result = i_a & i_b;
      OpOr:          o_result = i_a | i_b;
      OpSlt, OpSlti: o_result = {{(XLEN-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
`ifdef MIPS32_MUL_EN
      OpMul:         o_result = i_a * i_b;
`endif
      default:       ;
    endcase
  end

endmodule

// File: rtl/mips32_pipeline.sv
// 5-stage MIPS-subset core with internal register file and unified word-addressed memory.
// Define MIPS32_MUL_EN to execute MUL; otherwise MUL retires as a NOP.
module mips32_pipeline #(
  parameter int unsigned MEM_DEPTH = 1024,
  parameter int unsigned XLEN      = 32
) (
  input  logic            clk,
  input  logic            rst,
  output logic            halted,
  output logic [XLEN-1:0] pc
);
  import mips32_pkg::*;

  localparam int unsigned AddrW = $clog2(MEM_DEPTH);

  logic [31:0] PC;
  logic        HALTED;
  logic        TAKEN_BRANCH;
  word_t       Reg [0:31];
  word_t       mem [0:MEM_DEPTH-1];

  if_id_t  r_if_id;
  id_ex_t  r_id_ex,  w_id_ex_d;
  ex_mem_t r_ex_mem, w_ex_mem_d;
  mem_wb_t r_mem_wb, w_mem_wb_d;

  logic             w_wb_we, w_exm_fwd, w_taken;
  logic             w_id_hlt, w_fetch_stop, w_retire_hlt;
  word_t            w_fwd_a, w_fwd_b, w_alu_b, w_alu_out, w_target;
  logic [AddrW-1:0] w_mem_addr;

  assign w_wb_we = r_mem_wb.valid && r_mem_wb.wr_en;

  // ID: register read with write-through of the result retiring this cycle
  always_comb begin
    w_id_ex_d       = '0;
    w_id_ex_d.valid = r_if_id.valid;
    w_id_ex_d.pc    = r_if_id.pc;
    w_id_ex_d.op    = r_if_id.ir[31:26];
    w_id_ex_d.rs    = r_if_id.ir[25:21];
    w_id_ex_d.rt    = r_if_id.ir[20:16];
    w_id_ex_d.rd    = r_if_id.ir[15:11];
    w_id_ex_d.cls   = r_if_id.valid ? decode_class(r_if_id.ir[31:26]) : NOP;
    w_id_ex_d.imm   = {{16{r_if_id.ir[15]}}, r_if_id.ir[15:0]};
    w_id_ex_d.a     = Reg[w_id_ex_d.rs];
    w_id_ex_d.b     = Reg[w_id_ex_d.rt];
    if (w_wb_we && r_mem_wb.dest == w_id_ex_d.rs) w_id_ex_d.a = r_mem_wb.result;
    if (w_wb_we && r_mem_wb.dest == w_id_ex_d.rt) w_id_ex_d.b = r_mem_wb.result;
    if (w_id_ex_d.rs == 5'd0) w_id_ex_d.a = '0;
    if (w_id_ex_d.rt == 5'd0) w_id_ex_d.b = '0;
  end

  // A load in EX/MEM has no data yet, so the consumer falls through to older values.
  assign w_exm_fwd = r_ex_mem.valid && r_ex_mem.wr_en && (r_ex_mem.cls != LOAD);

  always_comb begin
    w_fwd_a = r_id_ex.a;
    w_fwd_b = r_id_ex.b;
    if (w_wb_we && r_mem_wb.dest == r_id_ex.rs) w_fwd_a = r_mem_wb.result;
    if (w_wb_we && r_mem_wb.dest == r_id_ex.rt) w_fwd_b = r_mem_wb.result;
    if (w_exm_fwd && r_ex_mem.dest == r_id_ex.rs) w_fwd_a = r_ex_mem.alu_out;
    if (w_exm_fwd && r_ex_mem.dest == r_id_ex.rt) w_fwd_b = r_ex_mem.alu_out;
  end

  assign w_alu_b = (r_id_ex.cls == RR_ALU) ? w_fwd_b : r_id_ex.imm;

  mips32_alu u_alu (
    .i_opcode (r_id_ex.op),
    .i_a      (w_fwd_a),
    .i_b      (w_alu_b),
    .o_result (w_alu_out)
  );

  assign w_taken  = r_id_ex.valid && (r_id_ex.cls == BRANCH) &&
                    (((r_id_ex.op == OpBeqz)  && (w_fwd_a == '0)) ||
                     ((r_id_ex.op == OpBneqz) && (w_fwd_a != '0)));
  assign w_target = r_id_ex.pc + 32'd1 + r_id_ex.imm;

  always_comb begin
    w_ex_mem_d         = '0;
    w_ex_mem_d.valid   = r_id_ex.valid;
    w_ex_mem_d.cls     = r_id_ex.cls;
    w_ex_mem_d.alu_out = w_alu_out;
    w_ex_mem_d.b       = w_fwd_b;
    w_ex_mem_d.dest    = (r_id_ex.cls == RR_ALU) ? r_id_ex.rd : r_id_ex.rt;
    w_ex_mem_d.wr_en   = r_id_ex.valid && (r_id_ex.cls inside {RR_ALU, RM_ALU, LOAD}) &&
                         (w_ex_mem_d.dest != 5'd0);
  end

  assign w_mem_addr = r_ex_mem.alu_out[AddrW-1:0];

  always_comb begin
    w_mem_wb_d        = '0;
    w_mem_wb_d.valid  = r_ex_mem.valid;
    w_mem_wb_d.cls    = r_ex_mem.cls;
    w_mem_wb_d.result = (r_ex_mem.cls == LOAD) ? mem[w_mem_addr] : r_ex_mem.alu_out;
    w_mem_wb_d.dest   = r_ex_mem.dest;
    w_mem_wb_d.wr_en  = r_ex_mem.wr_en;
  end

  // An HLT past ID can no longer be flushed, so any of them keeps fetch stopped.
  assign w_id_hlt     = r_if_id.valid && (w_id_ex_d.cls == HALT) && !w_taken;
  assign w_retire_hlt = r_mem_wb.valid && (r_mem_wb.cls == HALT);
  assign w_fetch_stop = w_id_hlt || w_retire_hlt ||
                        (r_id_ex.valid && (r_id_ex.cls == HALT)) ||
                        (r_ex_mem.valid && (r_ex_mem.cls == HALT));

  always_ff @(posedge clk) begin
    if (rst) begin
      PC           <= '0;
      HALTED       <= 1'b0;
      TAKEN_BRANCH <= 1'b0;
      r_if_id      <= '0;
      r_id_ex      <= '0;
      r_ex_mem     <= '0;
      r_mem_wb     <= '0;
    end else if (!HALTED) begin
      TAKEN_BRANCH <= w_taken;
      HALTED       <= w_retire_hlt;
      r_ex_mem     <= w_ex_mem_d;
      r_mem_wb     <= w_mem_wb_d;
      if (w_taken) begin
        PC      <= w_target;
        r_if_id <= '0;
        r_id_ex <= '0;
      end else begin
        r_id_ex <= w_id_ex_d;
        if (w_fetch_stop) begin
          r_if_id <= '0;
        end else begin
          PC            <= PC + 32'd1;
          r_if_id.valid <= 1'b1;
          r_if_id.pc    <= PC;
          r_if_id.ir    <= mem[PC[AddrW-1:0]];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !HALTED) begin
      if (w_wb_we) Reg[r_mem_wb.dest] <= r_mem_wb.result;
      if (r_ex_mem.valid && (r_ex_mem.cls == STORE)) mem[w_mem_addr] <= r_ex_mem.b;
    end
  end

  assign halted = HALTED;
  assign pc     = PC;

endmodule

// File: tb/tb_mips32_pipeline.sv
// Directed programs for mips32_pipeline with hand-computed register, memory and PC results.
module tb_mips32_pipeline;

  localparam logic [5:0] OpAdd = 6'b000000, OpSub = 6'b000001, OpAnd = 6'b000010;
  localparam logic [5:0] OpOr = 6'b000011, OpSlt = 6'b000100, OpMul = 6'b000101;
  localparam logic [5:0] OpLw = 6'b001000, OpSw = 6'b001001, OpAddi = 6'b001010;
  localparam logic [5:0] OpSubi = 6'b001011, OpSlti = 6'b001100, OpBneqz = 6'b001101;
  localparam logic [31:0] Hlt = 32'hFC00_0000;
  localparam logic [31:0] Nop = 32'h4000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        halted;
  logic [31:0] pc;
  int          checks = 0;
  int          errors = 0;
  int          n, tk;

  mips32_pipeline #(.MEM_DEPTH(1024), .XLEN(32)) dut (
    .clk    (clk),
    .rst    (rst),
    .halted (halted),
    .pc     (pc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rr(input logic [5:0] op, input logic [4:0] rd,
                                     input logic [4:0] rs, input logic [4:0] rt);
    return {op, rs, rt, rd, 11'd0};
  endfunction

  function automatic logic [31:0] ri(input logic [5:0] op, input logic [4:0] rt,
                                     input logic [4:0] rs, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic begin_load();
    rst = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 1024; i++) dut.mem[i] = '0;
    for (int k = 0; k < 32; k++) dut.Reg[k] = 32'(k);
  endtask

  task automatic release_rst();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic run_to_halt(input int budget, output int edges, output int taken);
    edges = 0;
    taken = 0;
    while (halted !== 1'b1 && edges < budget) begin
      @(posedge clk); #1;
      edges++;
      if (dut.TAKEN_BRANCH === 1'b1) taken++;
    end
    chk("halt_reached", {31'd0, halted}, 32'd1);
  endtask

  task automatic load_prog1();
    dut.mem[0] = ri(OpAddi, 1, 0, 16'd10);
    dut.mem[1] = ri(OpAddi, 2, 0, 16'd20);
    dut.mem[2] = ri(OpAddi, 3, 0, 16'd25);
    dut.mem[3] = rr(OpOr, 7, 7, 7);
    dut.mem[4] = rr(OpOr, 7, 7, 7);
    dut.mem[5] = rr(OpAdd, 4, 1, 2);
    dut.mem[6] = rr(OpOr, 7, 7, 7);
    dut.mem[7] = rr(OpAdd, 5, 4, 3);
    dut.mem[8] = Hlt;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "simulation time limit");
  end

  initial begin
    // Basic program; reset state first
    begin_load();
    chk("rst_pc", pc, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("rst_taken", {31'd0, dut.TAKEN_BRANCH}, 32'd0);
    load_prog1();
    release_rst();
    run_to_halt(14, n, tk);
    chk("t1_halt_edge", n, 32'd13);
    chk("t1_r1", dut.Reg[1], 32'd10);
    chk("t1_r2", dut.Reg[2], 32'd20);
    chk("t1_r3", dut.Reg[3], 32'd25);
    chk("t1_r4", dut.Reg[4], 32'd30);
    chk("t1_r5", dut.Reg[5], 32'd55);
    chk("t1_r7", dut.Reg[7], 32'd7);
    chk("t1_pc", pc, 32'd9);
    repeat (5) @(posedge clk);
    #1;
    chk("t1_pc_frozen", pc, 32'd9);

    // Back-to-back forwarding and ALU operations
    begin_load();
    dut.mem[0]  = ri(OpAddi, 1, 0, 16'd5);
    dut.mem[1]  = rr(OpAdd, 2, 1, 1);
    dut.mem[2]  = rr(OpSub, 3, 2, 1);
    dut.mem[3]  = rr(OpMul, 6, 2, 3);
    dut.mem[4]  = rr(OpSlt, 8, 3, 2);
    dut.mem[5]  = ri(OpSlti, 9, 1, 16'hFFFF);
    dut.mem[6]  = ri(OpSubi, 10, 0, 16'd7);
    dut.mem[7]  = rr(OpSlt, 11, 10, 1);
    dut.mem[8]  = rr(OpAnd, 12, 2, 3);
    dut.mem[9]  = rr(OpOr, 13, 2, 3);
    dut.mem[10] = ri(OpAddi, 0, 0, 16'd9);
    dut.mem[11] = rr(OpAdd, 14, 0, 0);
    dut.mem[12] = ri(OpAddi, 15, 0, 16'd1);
    dut.mem[13] = ri(OpAddi, 15, 15, 16'd1);
    dut.mem[14] = rr(OpAdd, 16, 15, 0);
    dut.mem[15] = Hlt;
    release_rst();
    run_to_halt(30, n, tk);
    chk("t2_r2", dut.Reg[2], 32'd10);
    chk("t2_r3", dut.Reg[3], 32'd5);
`ifdef MIPS32_MUL_EN
    chk("t2_mul", dut.Reg[6], 32'd50);
`else
    chk("t2_mul", dut.Reg[6], 32'd6);
`endif
    chk("t2_slt", dut.Reg[8], 32'd1);
    chk("t2_slti", dut.Reg[9], 32'd0);
    chk("t2_subi", dut.Reg[10], 32'hFFFF_FFF9);
    chk("t2_slt_neg", dut.Reg[11], 32'd1);
    chk("t2_and", dut.Reg[12], 32'd0);
    chk("t2_or", dut.Reg[13], 32'd15);
    chk("t2_r0", dut.Reg[0], 32'd0);
    chk("t2_r14", dut.Reg[14], 32'd0);
    chk("t2_r15", dut.Reg[15], 32'd2);
    chk("t2_fwd_prio", dut.Reg[16], 32'd2);

    // Store, load and load-use behaviour
    begin_load();
    dut.mem[0] = ri(OpAddi, 1, 0, 16'd100);
    dut.mem[1] = ri(OpAddi, 2, 0, 16'd77);
    dut.mem[2] = ri(OpSw, 2, 1, 16'd20);
    dut.mem[3] = ri(OpLw, 3, 1, 16'd20);
    dut.mem[4] = Nop;
    dut.mem[5] = rr(OpAdd, 4, 3, 3);
    dut.mem[6] = ri(OpLw, 5, 1, 16'd20);
    dut.mem[7] = rr(OpAdd, 6, 5, 0);
    dut.mem[8] = Hlt;
    release_rst();
    run_to_halt(30, n, tk);
    chk("t3_mem120", dut.mem[120], 32'd77);
    chk("t3_r3", dut.Reg[3], 32'd77);
    chk("t3_r4", dut.Reg[4], 32'd154);
    chk("t3_r5", dut.Reg[5], 32'd77);
    chk("t3_load_use", dut.Reg[6], 32'd5);

    // Counted loop with taken branches and a flushed HLT in the shadow
    begin_load();
    dut.mem[0] = ri(OpAddi, 1, 0, 16'd3);
    dut.mem[1] = ri(OpAddi, 2, 2, 16'd2);
    dut.mem[2] = ri(OpSubi, 1, 1, 16'd1);
    dut.mem[3] = ri(OpBneqz, 0, 1, 16'hFFFD);
    dut.mem[4] = Hlt;
    dut.mem[5] = ri(OpAddi, 9, 0, 16'd99);
    release_rst();
    run_to_halt(40, n, tk);
    chk("t4_r1", dut.Reg[1], 32'd0);
    chk("t4_r2", dut.Reg[2], 32'd8);
    chk("t4_shadow", dut.Reg[9], 32'd9);
    chk("t4_taken_cnt", tk, 32'd2);
    chk("t4_pc", pc, 32'd5);

    // Store placed after HLT never executes
    begin_load();
    dut.mem[10] = 32'hDEAD_BEEF;
    dut.mem[0]  = ri(OpAddi, 1, 0, 16'd50);
    dut.mem[1]  = Hlt;
    dut.mem[2]  = ri(OpSw, 1, 0, 16'd10);
    release_rst();
    run_to_halt(20, n, tk);
    repeat (20) @(posedge clk);
    #1;
    chk("t5_halted", {31'd0, halted}, 32'd1);
    chk("t5_pc", pc, 32'd2);
    chk("t5_r1", dut.Reg[1], 32'd50);
    chk("t5_mem10", dut.mem[10], 32'hDEAD_BEEF);

    // Reset while the pipeline is full, then rerun
    begin_load();
    load_prog1();
    release_rst();
    repeat (7) @(posedge clk);
    #1;
    chk("t6_r3_early", dut.Reg[3], 32'd25);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("t6_rst_pc", pc, 32'd0);
    chk("t6_rst_halted", {31'd0, halted}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("t6_r4_kept", dut.Reg[4], 32'd4);
    chk("t6_r5_kept", dut.Reg[5], 32'd5);
    rst = 1'b0;
    run_to_halt(20, n, tk);
    chk("t6_halt_edge", n, 32'd13);
    chk("t6_r4", dut.Reg[4], 32'd30);
    chk("t6_r5", dut.Reg[5], 32'd55);
    chk("t6_pc", pc, 32'd9);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
